stream_deinterleaver: RTL

STREAM_DEINTERLEAVER -- requirements
Module: stream_deinterleaver

---
 rtl/stream_deinterleaver.sv | 84 ++++++++
 1 files changed

// File: rtl/stream_deinterleaver.sv
// Splits one valid/ready input stream into two lanes, alternating beats lane 0, lane 1, ...
// Each lane is a small FIFO; in_ready looks only at the lane whose turn it is.
module stream_deinterleaver #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_WIDTH-1:0]           lane0_data,
    output logic                            lane0_valid,
    input  logic                            lane0_ready,
    output logic [DATA_WIDTH-1:0]           lane1_data,
    output logic                            lane1_valid,
    input  logic                            lane1_ready,
    output logic                            in_sel,
    output logic [$clog2(2*LANE_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(LANE_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(2*LANE_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem    [2][LANE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [2];
    logic [PTR_W-1:0]      rd_ptr [2];
    logic [OCC_W-1:0]      occ    [2];

    logic [1:0] lane_ready;
    logic [1:0] lane_valid;
    logic [1:0] rd_fire;
    logic [1:0] wr_fire;
    logic       in_fire;

    // in_ready comes from registered occupancy only, so a read frees space one cycle later
    always_comb begin
        lane_ready = {lane1_ready, lane0_ready};
        lane_valid = {occ[1] != '0, occ[0] != '0};
        rd_fire    = lane_valid & lane_ready;
        in_ready   = (occ[in_sel] != OCC_W'(LANE_DEPTH));
        in_fire    = in_valid & in_ready;
        wr_fire    = {in_fire & in_sel, in_fire & ~in_sel};
    end

    assign lane0_valid = lane_valid[0];
    assign lane1_valid = lane_valid[1];
    assign lane0_data  = mem[0][rd_ptr[0]];
    assign lane1_data  = mem[1][rd_ptr[1]];
    assign count       = CNT_W'(occ[0]) + CNT_W'(occ[1]);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            in_sel <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                occ[k]    <= '0;
                for (int e = 0; e < LANE_DEPTH; e++) begin
                    mem[k][e] <= '0;
                end
            end
        end else begin
            if (in_fire) begin
                in_sel <= ~in_sel;
            end
            for (int k = 0; k < 2; k++) begin
                if (wr_fire[k]) begin
                    mem[k][wr_ptr[k]] <= in_data;
                    wr_ptr[k]         <= wr_ptr[k] + PTR_W'(1);
                end
                if (rd_fire[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                if (wr_fire[k] && !rd_fire[k]) begin
                    occ[k] <= occ[k] + OCC_W'(1);
                end else if (!wr_fire[k] && rd_fire[k]) begin
                    occ[k] <= occ[k] - OCC_W'(1);
                end
            end
        end
    end
endmodule
